jacobi_seq_ctrl: RTL and testbench

- Input-stream parser and iteration sequencer for the Jacobi solver datapath.
- Consumes the serial 32-bit word stream on din (header, then matrix A, vector b and initial guess) and writes it into the datapath's A/b/x memories.
- Then issues one start pulse per Jacobi sweep until the datapath reports convergence or the iteration limit is reached, and finally raises drdy.
- Sits between the top-level din/go pins and the datapath/memories inside top.

---
 rtl/jacobi_pkg.sv | 23 ++
 rtl/jacobi_rc_counter.sv | 38 +++
 rtl/jacobi_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_jacobi_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacobi_pkg.sv
// Shared types and constants for the Jacobi input-stream sequencer.
package jacobi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_LOAD_X = 3'd4,
    ST_ITER   = 3'd5,
    ST_WAIT   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_X = 2'd2;

  localparam logic [1:0] HDR_N     = 2'd0;
  localparam logic [1:0] HDR_MAXIT = 2'd1;
  localparam logic [1:0] HDR_TOL   = 2'd2;

endpackage

// File: rtl/jacobi_rc_counter.sv
// Row/column counter with programmable order n; addr = row*n + col.
// In linear mode row stays at 0 and col simply counts.
module jacobi_rc_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         lin,
  input  logic [W-1:0] n,
  output logic [W-1:0] addr,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] row;
  logic [W-1:0] col;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (!lin && (col == n - ONE)) begin
        col <= '0;
        row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

  assign addr = row * n + col;
  assign last = (col == n - ONE) && (lin || (row == n - ONE));

endmodule

// File: rtl/jacobi_seq_ctrl.sv
// Jacobi stream parser and sweep sequencer: loads A/b/x memories from din,
// then issues sweeps until convergence or MAX_ITER. Optional watchdog: JSEQ_WDOG_EN.
module jacobi_seq_ctrl
  import jacobi_pkg::*;
#(
  parameter int unsigned N_MAX    = 64,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WDOG_CYC = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [31:0]       din,
  input  logic              din_vld,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       n_out,
  output logic [31:0]       tol_out,
  output logic              iter_start,
  input  logic              iter_done,
  input  logic              converged,
  output logic [31:0]       iter_cnt,
  output logic              drdy,
  output logic              err,
  output logic [2:0]        s
);

  state_t      state, state_nxt;
  logic [31:0] n_full, max_iter, tol_r, x0_r, iter_cnt_r;
  logic [1:0]  hdr_idx;
  logic        xphase;
  logic        err_r;
  logic        n_bad;
  logic        wdog_hit;

  logic              rc_clr, rc_en, rc_lin, rc_last;
  logic [ADDR_W-1:0] rc_addr;

  jacobi_rc_counter #(.W(ADDR_W)) u_rc (
    .clk   (clk),
    .reset (reset),
    .clr   (rc_clr),
    .en    (rc_en),
    .lin   (rc_lin),
    .n     (n_full[ADDR_W-1:0]),
    .addr  (rc_addr),
    .last  (rc_last)
  );

  assign n_bad = (n_full == '0) || (n_full > 32'(N_MAX));

`ifdef JSEQ_WDOG_EN
  logic [31:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (reset || (state != ST_WAIT)) wdog_cnt <= '0;
    else                             wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign wdog_hit = (wdog_cnt == 32'(WDOG_CYC - 1));
`else
  assign wdog_hit = 1'b0 && (WDOG_CYC != 0);
`endif

  always_comb begin
    state_nxt  = state;
    mem_we     = 1'b0;
    mem_sel    = SEL_A;
    mem_addr   = '0;
    mem_wdata  = '0;
    iter_start = 1'b0;
    rc_en      = 1'b0;
    rc_clr     = 1'b0;
    rc_lin     = 1'b1;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_HDR;
      ST_HDR: begin
        if (din_vld && (hdr_idx == HDR_TOL)) begin
          rc_clr = 1'b1;
          if (n_bad || (max_iter == '0)) state_nxt = ST_DONE;
          else                           state_nxt = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        rc_lin    = 1'b0;
        mem_sel   = SEL_A;
        mem_addr  = rc_addr;
        mem_wdata = din;
        if (din_vld) begin
          mem_we = 1'b1;
          rc_en  = 1'b1;
          if (rc_last) begin
            rc_clr    = 1'b1;
            state_nxt = ST_LOAD_B;
          end
        end
      end
      ST_LOAD_B: begin
        mem_sel   = SEL_B;
        mem_addr  = rc_addr;
        mem_wdata = din;
        // After the N b-words the next valid word is x0: latched, not written.
        if (din_vld) begin
          if (!xphase) begin
            mem_we = 1'b1;
            if (rc_last) rc_clr = 1'b1;
            else         rc_en  = 1'b1;
          end else begin
            rc_clr    = 1'b1;
            state_nxt = ST_LOAD_X;
          end
        end
      end
      ST_LOAD_X: begin
        mem_we    = 1'b1;
        mem_sel   = SEL_X;
        mem_addr  = rc_addr;
        mem_wdata = x0_r;
        if (rc_last) begin
          rc_clr    = 1'b1;
          state_nxt = ST_ITER;
        end else begin
          rc_en = 1'b1;
        end
      end
      ST_ITER: begin
        iter_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (iter_done) begin
          if (converged || (iter_cnt_r + 32'd1 == max_iter)) state_nxt = ST_DONE;
          else                                              state_nxt = ST_ITER;
        end else if (wdog_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (!go) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      n_full     <= '0;
      max_iter   <= '0;
      tol_r      <= '0;
      x0_r       <= '0;
      iter_cnt_r <= '0;
      hdr_idx    <= '0;
      xphase     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          hdr_idx <= '0;
          xphase  <= 1'b0;
          if (go) begin
            err_r      <= 1'b0;
            iter_cnt_r <= '0;
          end
        end
        ST_HDR: begin
          if (din_vld) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              HDR_N:     n_full   <= din;
              HDR_MAXIT: max_iter <= din;
              default: begin
                tol_r <= din;
                if (n_bad) err_r <= 1'b1;
              end
            endcase
          end
        end
        ST_LOAD_B: begin
          if (din_vld) begin
            if (xphase) begin
              x0_r   <= din;
              xphase <= 1'b0;
            end else if (rc_last) begin
              xphase <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (iter_done)     iter_cnt_r <= iter_cnt_r + 32'd1;
          else if (wdog_hit) err_r      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign n_out    = n_full[15:0];
  assign tol_out  = tol_r;
  assign iter_cnt = iter_cnt_r;
  assign drdy     = (state == ST_DONE);
  assign err      = err_r;
  assign s        = state;

endmodule

// File: tb/tb_jacobi_seq_ctrl.sv
// Directed self-checking bench for jacobi_seq_ctrl with a simple datapath model.
module tb_jacobi_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, go, din_vld, iter_done, converged;
  logic [31:0] din;
  logic        mem_we, iter_start, drdy, err;
  logic [1:0]  mem_sel;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, tol_out, iter_cnt;
  logic [15:0] n_out;
  logic [2:0]  s;

  int checks = 0;
  int failures = 0;

  logic [31:0] wmem [0:2][0:63];
  int          wcnt [0:2];
  int          bad_wr, start_cnt, done_seen, conv_at;
  bit          model_en;
  logic [31:0] sa [0:15];
  logic [31:0] sb [0:3];

  jacobi_seq_ctrl #(.N_MAX(64), .ADDR_W(12), .WDOG_CYC(100)) dut (
    .clk(clk), .reset(reset), .go(go), .din(din), .din_vld(din_vld),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .n_out(n_out), .tol_out(tol_out), .iter_start(iter_start), .iter_done(iter_done),
    .converged(converged), .iter_cnt(iter_cnt), .drdy(drdy), .err(err), .s(s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (mem_sel < 2'd3 && mem_addr < 12'd64) begin
        wmem[mem_sel][mem_addr[5:0]] = mem_wdata;
        wcnt[mem_sel]++;
      end else begin
        bad_wr++;
      end
    end
    if (iter_start === 1'b1) start_cnt++;
  end

  // Datapath model: answers each sweep 3 cycles after iter_start.
  initial begin
    iter_done = 1'b0;
    converged = 1'b0;
    forever begin
      @(negedge clk);
      if (iter_start === 1'b1 && model_en) begin
        repeat (3) @(posedge clk);
        #2;
        done_seen++;
        iter_done = 1'b1;
        converged = (conv_at != 0 && done_seen == conv_at);
        @(posedge clk);
        #2;
        iter_done = 1'b0;
        converged = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clr_mon;
    for (int i = 0; i < 3; i++) begin
      wcnt[i] = 0;
      for (int j = 0; j < 64; j++) wmem[i][j] = 32'hFFFF_FFFF;
    end
    bad_wr = 0; start_cnt = 0; done_seen = 0;
  endtask

  task automatic set_a2;
    sa[0] = 32'd4; sa[1] = 32'd1; sa[2] = 32'd1; sa[3] = 32'd3;
    sb[0] = 32'd1; sb[1] = 32'd2;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    din = w;
    din_vld = 1'b1;
    tick;
    din_vld = 1'b0;
    if (gap) tick;
  endtask

  task automatic send_stream(input int n, input logic [31:0] maxit, input logic [31:0] tol,
                             input logic [31:0] x0, input bit gap, input bit drop_go);
    go = 1'b1;
    tick;
    send_word(32'(n), gap);
    send_word(maxit, gap);
    send_word(tol, gap);
    if (drop_go) go = 1'b0;
    for (int i = 0; i < n * n; i++) send_word(sa[i], gap);
    for (int i = 0; i < n; i++) send_word(sb[i], gap);
    send_word(x0, gap);
  endtask

  task automatic wait_drdy(input int maxcyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxcyc; k++) begin
      @(negedge clk);
      if (drdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; din_vld = 1'b0; din = '0;
    tick; tick;
    @(negedge clk);
    checks++;
    if ({s, mem_we, drdy, iter_start, err} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000000", {s, mem_we, drdy, iter_start, err});
    end
    checks++;
    if ({iter_cnt, n_out, tol_out} !== 80'd0) begin
      failures++; $display("FAIL reset_regs: got iter_cnt=%0d n_out=%0d tol=%0h expected 0", iter_cnt, n_out, tol_out);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    bit ok;
    int lat;
    clr_mon; set_a2; model_en = 1'b1; conv_at = 0;
    send_stream(2, 32'd5, 32'h3A83_126F, 32'd0, 1'b0, 1'b0);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (iter_start === 1'b1) break;
      lat++;
    end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    wait_drdy(300, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL basic_drdy: got %0d expected 1", ok); end
    checks++;
    if (iter_cnt !== 32'd5) begin failures++; $display("FAIL basic_iter_cnt: got %0d expected 5", iter_cnt); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %0d expected 0", err); end
    checks++;
    if (start_cnt !== 5) begin failures++; $display("FAIL basic_starts: got %0d expected 5", start_cnt); end
    checks++;
    if ({wcnt[0], wcnt[1], wcnt[2], bad_wr} !== {32'd4, 32'd2, 32'd2, 32'd0}) begin
      failures++; $display("FAIL basic_wcnt: got %0d/%0d/%0d bad=%0d expected 4/2/2 bad=0", wcnt[0], wcnt[1], wcnt[2], bad_wr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wmem[0][i] !== sa[i]) begin failures++; $display("FAIL basic_a[%0d]: got %0d expected %0d", i, wmem[0][i], sa[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wmem[1][i] !== sb[i]) begin failures++; $display("FAIL basic_b[%0d]: got %0d expected %0d", i, wmem[1][i], sb[i]); end
      checks++;
      if (wmem[2][i] !== 32'd0) begin failures++; $display("FAIL basic_x[%0d]: got %0d expected 0", i, wmem[2][i]); end
    end
    checks++;
    if ({n_out, tol_out} !== {16'd2, 32'h3A83_126F}) begin
      failures++; $display("FAIL basic_latched: got n=%0d tol=%0h expected n=2 tol=3a83126f", n_out, tol_out);
    end
    go = 1'b0;
    @(negedge clk);
    checks++;
    if ({s, drdy, iter_cnt} !== {3'd0, 1'b0, 32'd5}) begin
      failures++; $display("FAIL basic_release: got s=%0d drdy=%0d iter_cnt=%0d expected s=0 drdy=0 iter_cnt=5", s, drdy, iter_cnt);
    end
    tick;
  endtask

  task automatic test_converge;
    bit ok;
    clr_mon; set_a2; model_en = 1'b1; conv_at = 3;
    send_stream(2, 32'd5, 32'h1, 32'd0, 1'b0, 1'b0);
    wait_drdy(300, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL conv_drdy: got %0d expected 1", ok); end
    checks++;
    if (iter_cnt !== 32'd3) begin failures++; $display("FAIL conv_iter_cnt: got %0d expected 3", iter_cnt); end
    repeat (5) @(negedge clk);
    checks++;
    if ({start_cnt, err} !== {32'd3, 1'b0}) begin
      failures++; $display("FAIL conv_starts: got starts=%0d err=%0d expected starts=3 err=0", start_cnt, err);
    end
    go = 1'b0; conv_at = 0;
    tick;
  endtask

  task automatic test_bad_n;
    logic [31:0] nv [0:1];
    nv[0] = 32'd0; nv[1] = 32'd65;
    for (int t = 0; t < 2; t++) begin
      clr_mon;
      go = 1'b1; tick;
      send_word(nv[t], 1'b0); send_word(32'd5, 1'b0); send_word(32'd7, 1'b0);
      @(negedge clk);
      checks++;
      if ({s, drdy, err} !== {3'd7, 1'b1, 1'b1}) begin
        failures++; $display("FAIL badn_%0d_state: got s=%0d drdy=%0d err=%0d expected s=7 drdy=1 err=1", nv[t], s, drdy, err);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({wcnt[0], wcnt[1], wcnt[2], bad_wr, start_cnt} !== 160'd0) begin
        failures++; $display("FAIL badn_%0d_quiet: got writes=%0d/%0d/%0d starts=%0d expected 0", nv[t], wcnt[0], wcnt[1], wcnt[2], start_cnt);
      end
      go = 1'b0;
      @(negedge clk);
      checks++;
      if ({s, drdy, err} !== {3'd0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL badn_%0d_hold: got s=%0d drdy=%0d err=%0d expected s=0 drdy=0 err=1", nv[t], s, drdy, err);
      end
      tick;
    end
    clr_mon;
    go = 1'b1; tick;
    send_word(32'd2, 1'b0); send_word(32'd0, 1'b0); send_word(32'd7, 1'b0);
    @(negedge clk);
    checks++;
    if ({s, drdy, err, iter_cnt} !== {3'd7, 1'b1, 1'b0, 32'd0}) begin
      failures++; $display("FAIL maxit0: got s=%0d drdy=%0d err=%0d iter_cnt=%0d expected s=7 drdy=1 err=0 iter_cnt=0", s, drdy, err, iter_cnt);
    end
    go = 1'b0;
    tick;
  endtask

  task automatic test_gaps;
    bit ok;
    clr_mon; model_en = 1'b1; conv_at = 0;
    for (int i = 0; i < 9; i++) sa[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 3; i++) sb[i] = 32'h200 + 32'(i);
    send_stream(3, 32'd2, 32'h5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    wait_drdy(300, ok);
    checks++;
    if ({ok, iter_cnt} !== {1'b1, 32'd2}) begin
      failures++; $display("FAIL gaps_done: got drdy=%0d iter_cnt=%0d expected drdy=1 iter_cnt=2", ok, iter_cnt);
    end
    checks++;
    if ({wcnt[0], wcnt[1], wcnt[2], bad_wr} !== {32'd9, 32'd3, 32'd3, 32'd0}) begin
      failures++; $display("FAIL gaps_wcnt: got %0d/%0d/%0d bad=%0d expected 9/3/3 bad=0", wcnt[0], wcnt[1], wcnt[2], bad_wr);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (wmem[0][i] !== sa[i]) begin failures++; $display("FAIL gaps_a[%0d]: got %0h expected %0h", i, wmem[0][i], sa[i]); end
    end
    checks++;
    if (wmem[0][5] !== 32'h105) begin failures++; $display("FAIL gaps_a_r1c2: got %0h expected 105", wmem[0][5]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wmem[1][i] !== sb[i]) begin failures++; $display("FAIL gaps_b[%0d]: got %0h expected %0h", i, wmem[1][i], sb[i]); end
      checks++;
      if (wmem[2][i] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL gaps_x[%0d]: got %0h expected deadbeef", i, wmem[2][i]); end
    end
    go = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    bit ok;
    clr_mon;
    for (int i = 0; i < 9; i++) sa[i] = 32'h300 + 32'(i);
    go = 1'b1; tick;
    send_word(32'd3, 1'b0); send_word(32'd4, 1'b0); send_word(32'd9, 1'b0);
    for (int i = 0; i < 4; i++) send_word(sa[i], 1'b0);
    din = sa[4]; din_vld = 1'b1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_we: got %0d expected 0", mem_we); end
    @(negedge clk);
    checks++;
    if ({s, mem_we, drdy, iter_start, err, iter_cnt, n_out, tol_out} !== 87'd0) begin
      failures++; $display("FAIL rstmid_outputs: got s=%0d we=%0d n=%0d tol=%0h expected all 0", s, mem_we, n_out, tol_out);
    end
    reset = 1'b0; din_vld = 1'b0; go = 1'b0;
    tick;
    clr_mon; set_a2; model_en = 1'b1; conv_at = 0;
    send_stream(2, 32'd5, 32'h2, 32'd7, 1'b0, 1'b1);
    wait_drdy(300, ok);
    checks++;
    if ({ok, iter_cnt, err} !== {1'b1, 32'd5, 1'b0}) begin
      failures++; $display("FAIL rstmid_rerun: got drdy=%0d iter_cnt=%0d err=%0d expected 1/5/0", ok, iter_cnt, err);
    end
    checks++;
    if ({wcnt[0], wcnt[1], wcnt[2], start_cnt} !== {32'd4, 32'd2, 32'd2, 32'd5}) begin
      failures++; $display("FAIL rstmid_counts: got %0d/%0d/%0d starts=%0d expected 4/2/2 starts=5", wcnt[0], wcnt[1], wcnt[2], start_cnt);
    end
    checks++;
    if ({wmem[0][1], wmem[2][1]} !== {32'd1, 32'd7}) begin
      failures++; $display("FAIL rstmid_data: got a1=%0d x1=%0d expected a1=1 x1=7", wmem[0][1], wmem[2][1]);
    end
    tick;
  endtask

`ifdef JSEQ_WDOG_EN
  task automatic test_wdog;
    int k;
    bit seen;
    clr_mon; set_a2; model_en = 1'b0;
    send_stream(2, 32'd5, 32'h1, 32'd0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iter_start === 1'b1) begin seen = 1'b1; break; end
    end
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s === 3'd7) break;
      k++;
    end
    checks++;
    if ({seen, k} !== {1'b1, 32'd100}) begin
      failures++; $display("FAIL wdog_cycles: got start=%0d wait_cycles=%0d expected start=1 wait_cycles=100", seen, k);
    end
    checks++;
    if ({drdy, err, iter_cnt} !== {1'b1, 1'b1, 32'd0}) begin
      failures++; $display("FAIL wdog_flags: got drdy=%0d err=%0d iter_cnt=%0d expected 1/1/0", drdy, err, iter_cnt);
    end
    go = 1'b0; model_en = 1'b1;
    tick;
  endtask
`endif

  initial begin
    reset = 1'b1; go = 1'b0; din = '0; din_vld = 1'b0;
    model_en = 1'b1; conv_at = 0;
    clr_mon;
    test_reset;
    test_basic;
    test_converge;
    test_bad_n;
    test_gaps;
    test_reset_mid;
`ifdef JSEQ_WDOG_EN
    test_wdog;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
